// File: rtl/max_argmax_pkg.sv
// Shared types, tie-policy constants and the element comparison for max_argmax_stream.
// Define MAX_ARGMAX_SIGNED_EN to compare elements as two's-complement signed values.
package max_argmax_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_ACC   = 1'b1
   } state_t;

   localparam int TIE_POLICY_FIRST = 0;
   localparam int TIE_POLICY_LAST  = 1;

   // Operands arrive zero-extended to 64 bits; w is the real element width.
   function automatic logic elem_gt(input logic [63:0] a,
                                    input logic [63:0] b,
                                    input int unsigned w);
`ifdef MAX_ARGMAX_SIGNED_EN
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      // Left-align so the element sign bit becomes bit 63.
      sa = signed'(a << (64 - w));
      sb = signed'(b << (64 - w));
      return sa > sb;
`else
      return a > b;
`endif
   endfunction

endpackage

// File: rtl/max_argmax_cmp.sv
// Combinational running-max update: keeps (cur_max, cur_arg) or takes (cand, idx).
module max_argmax_cmp
   import max_argmax_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SIZE     = 3,
   parameter int          TIE_LAST = 1
) (
   input  logic [WIDTH-1:0] cur_max,
   input  logic [SIZE-1:0]  cur_arg,
   input  logic [WIDTH-1:0] cand,
   input  logic [SIZE-1:0]  idx,
   output logic [WIDTH-1:0] new_max,
   output logic [SIZE-1:0]  new_arg
);

   logic take;

   always_comb begin
      take = elem_gt(64'(cand), 64'(cur_max), WIDTH) ||
             ((TIE_LAST == TIE_POLICY_LAST) && (cand == cur_max));
      new_max = take ? cand : cur_max;
      new_arg = take ? idx  : cur_arg;
   end

endmodule

// File: rtl/max_argmax_stream.sv
// Streaming per-frame max/argmax with valid/ready on both sides and one-cycle result latency.
// Define MAX_ARGMAX_SIGNED_EN for signed element comparison (unsigned otherwise).
module max_argmax_stream
   import max_argmax_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SIZE     = 3,
   parameter int          TIE_LAST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [SIZE-1:0]  out_argmax,
   output logic [SIZE:0]    out_count
);

   state_t           state_p0;
   logic [WIDTH-1:0] run_max_p0;
   logic [SIZE-1:0]  run_arg_p0;
   logic [SIZE-1:0]  idx_p0;
   logic             vld_p1;

   logic [WIDTH-1:0] cmp_max;
   logic [SIZE-1:0]  cmp_arg;
   logic [WIDTH-1:0] nxt_max;
   logic [SIZE-1:0]  nxt_arg;
   logic [SIZE-1:0]  cur_idx;
   logic             accept;
   logic             close;

   max_argmax_cmp #(
      .WIDTH   (WIDTH),
      .SIZE    (SIZE),
      .TIE_LAST(TIE_LAST)
   ) u_cmp (
      .cur_max(run_max_p0),
      .cur_arg(run_arg_p0),
      .cand   (in_data),
      .idx    (idx_p0),
      .new_max(cmp_max),
      .new_arg(cmp_arg)
   );

   assign out_valid = vld_p1;
   assign in_ready  = !(vld_p1 && !out_ready);

   // Stage p0: merge the incoming element into the running frame state.
   always_comb begin
      accept  = in_valid && in_ready;
      cur_idx = (state_p0 == ST_EMPTY) ? '0 : idx_p0;
      nxt_max = (state_p0 == ST_EMPTY) ? in_data : cmp_max;
      nxt_arg = (state_p0 == ST_EMPTY) ? '0 : cmp_arg;
      close   = in_last || (cur_idx == '1);
   end

   // Stage p1: closed-frame result register and frame-state FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0   <= ST_EMPTY;
         run_max_p0 <= '0;
         run_arg_p0 <= '0;
         idx_p0     <= '0;
         vld_p1     <= 1'b0;
         out_max    <= '0;
         out_argmax <= '0;
         out_count  <= '0;
      end else begin
         if (vld_p1 && out_ready)
            vld_p1 <= 1'b0;
         if (accept) begin
            if (close) begin
               state_p0   <= ST_EMPTY;
               idx_p0     <= '0;
               vld_p1     <= 1'b1;
               out_max    <= nxt_max;
               out_argmax <= nxt_arg;
               out_count  <= (SIZE+1)'(cur_idx) + (SIZE+1)'(1);
            end else begin
               state_p0   <= ST_ACC;
               run_max_p0 <= nxt_max;
               run_arg_p0 <= nxt_arg;
               idx_p0     <= cur_idx + SIZE'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_max_argmax_stream.sv
// Bench for max_argmax_stream: directed vector table, reset sequences and randomized traffic
// against a frame-queue reference model; runs TIE_LAST=1 and TIE_LAST=0 instances side by side.
module tb_max_argmax_stream;

   localparam int W = 8;
   localparam int S = 3;
   localparam int FRAME_MAX = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         out_ready;

   logic         rdy_l, rdy_f, ov_l, ov_f;
   logic [W-1:0] max_l, max_f;
   logic [S-1:0] arg_l, arg_f;
   logic [S:0]   cnt_l, cnt_f;

   always #5 clk = ~clk;

   max_argmax_stream #(.WIDTH(W), .SIZE(S), .TIE_LAST(1)) u_last (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
      .in_last(in_last), .out_valid(ov_l), .out_ready(out_ready), .out_max(max_l),
      .out_argmax(arg_l), .out_count(cnt_l));

   max_argmax_stream #(.WIDTH(W), .SIZE(S), .TIE_LAST(0)) u_first (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f), .in_data(in_data),
      .in_last(in_last), .out_valid(ov_f), .out_ready(out_ready), .out_max(max_f),
      .out_argmax(arg_f), .out_count(cnt_f));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted elements of the open frame, plus the pending result.
   logic [W-1:0] frame[$];
   bit           m_valid = 1'b0;
   logic [W-1:0] m_max;
   int           m_a_last, m_a_first, m_cnt;

   function automatic bit gt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAX_ARGMAX_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   task automatic model_close();
      m_max = frame[0];
      m_a_last = 0;
      m_a_first = 0;
      for (int i = 1; i < frame.size(); i++) begin
         if (gt(frame[i], m_max)) begin
            m_max = frame[i];
            m_a_last = i;
            m_a_first = i;
         end else if (frame[i] == m_max) begin
            m_a_last = i;
         end
      end
      m_cnt = frame.size();
      frame.delete();
   endtask

   task automatic check_model();
      chk("out_valid_last", ov_l, m_valid);
      chk("out_valid_first", ov_f, m_valid);
      if (m_valid) begin
         chk("out_max_last", max_l, m_max);
         chk("out_max_first", max_f, m_max);
         chk("out_argmax_last", arg_l, m_a_last);
         chk("out_argmax_first", arg_f, m_a_first);
         chk("out_count_last", cnt_l, m_cnt);
         chk("out_count_first", cnt_f, m_cnt);
      end
   endtask

   // One clock cycle of stimulus; the model always tracks, and checks itself when use_model is set.
   task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit ordy,
                       input bit use_model, output logic seen_rdy_l, output logic seen_rdy_f);
      bit exp_rdy, consumed, closed;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      #1;
      seen_rdy_l = rdy_l;
      seen_rdy_f = rdy_f;
      exp_rdy  = !(m_valid && !ordy);
      if (use_model) begin
         chk("in_ready_last", rdy_l, exp_rdy);
         chk("in_ready_first", rdy_f, exp_rdy);
      end
      consumed = m_valid && ordy;
      closed   = 1'b0;
      if (v && exp_rdy) begin
         frame.push_back(d);
         if (l || frame.size() == FRAME_MAX) begin
            model_close();
            closed = 1'b1;
         end
      end
      if (closed) m_valid = 1'b1;
      else if (consumed) m_valid = 1'b0;
      @(posedge clk);
      #1;
      if (use_model) check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame.delete();
      m_valid = 1'b0;
      chk("rst_out_valid", ov_l, 0);
      chk("rst_out_max", max_l, 0);
      chk("rst_out_argmax", arg_l, 0);
      chk("rst_out_count", cnt_l, 0);
      chk("rst_out_valid_first", ov_f, 0);
   endtask

   typedef struct {
      bit           v;
      logic [W-1:0] d;
      bit           l;
      bit           ordy;
      bit           e_rdy;
      bit           e_ov;
      logic [W-1:0] e_max;
      int           e_a_last;
      int           e_a_first;
      int           e_cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic r_l, r_f;
      bit v, l, ordy;
      logic [W-1:0] d;

      // frame 10,20,5(last) then 42(last), back to back with result consumption
      tbl.push_back('{1, 8'd10, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd20, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd5,  1, 1, 1, 1, 8'd20, 1, 1, 3});
      tbl.push_back('{1, 8'd42, 1, 1, 1, 1, 8'd42, 0, 0, 1});
      tbl.push_back('{0, 8'd99, 1, 1, 1, 0, 8'd0,  0, 0, 0});
      // eight elements without in_last: auto-close at index 7
      tbl.push_back('{1, 8'd50, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd30, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd80, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd20, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd80, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd10, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd80, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd40, 0, 1, 1, 1, 8'd80, 6, 2, 8});
      // pending result with out_ready=0 stalls input and holds outputs
      tbl.push_back('{1, 8'd7,  0, 0, 0, 1, 8'd80, 6, 2, 8});
      tbl.push_back('{1, 8'd7,  0, 0, 0, 1, 8'd80, 6, 2, 8});
      tbl.push_back('{1, 8'd7,  0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd9,  1, 0, 1, 1, 8'd9,  1, 1, 2});
      tbl.push_back('{1, 8'd3,  1, 0, 0, 1, 8'd9,  1, 1, 2});
      tbl.push_back('{1, 8'd3,  1, 1, 1, 1, 8'd3,  0, 0, 1});
      // equal maxima
      tbl.push_back('{1, 8'd5,  0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd5,  1, 1, 1, 1, 8'd5,  1, 0, 2});
      // sign-sensitive frame
      tbl.push_back('{1, 8'h01, 0, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'h80, 0, 1, 1, 0, 8'd0,  0, 0, 0});
`ifdef MAX_ARGMAX_SIGNED_EN
      tbl.push_back('{1, 8'h7F, 1, 1, 1, 1, 8'h7F, 2, 2, 3});
`else
      tbl.push_back('{1, 8'h7F, 1, 1, 1, 1, 8'h80, 1, 1, 3});
`endif
      // idle input ignored, then a single-element frame
      tbl.push_back('{0, 8'hFF, 1, 1, 1, 0, 8'd0,  0, 0, 0});
      tbl.push_back('{1, 8'd1,  1, 1, 1, 1, 8'd1,  0, 0, 1});

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", ov_l, 0);
      chk("reset_out_max", max_l, 0);
      chk("reset_out_argmax", arg_l, 0);
      chk("reset_out_count", cnt_l, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", rdy_l, 1);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, 1'b0, r_l, r_f);
         chk($sformatf("vec%0d_in_ready", i), r_l, tbl[i].e_rdy);
         chk($sformatf("vec%0d_in_ready_first", i), r_f, tbl[i].e_rdy);
         chk($sformatf("vec%0d_out_valid", i), ov_l, tbl[i].e_ov);
         chk($sformatf("vec%0d_out_valid_first", i), ov_f, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            chk($sformatf("vec%0d_out_max", i), max_l, tbl[i].e_max);
            chk($sformatf("vec%0d_out_max_first", i), max_f, tbl[i].e_max);
            chk($sformatf("vec%0d_argmax_last", i), arg_l, tbl[i].e_a_last);
            chk($sformatf("vec%0d_argmax_first", i), arg_f, tbl[i].e_a_first);
            chk($sformatf("vec%0d_out_count", i), cnt_l, tbl[i].e_cnt);
         end
      end

      // reset three elements into a frame, then a fresh two-element frame
      step(1, 8'd11, 0, 1, 1'b1, r_l, r_f);
      step(1, 8'd22, 0, 1, 1'b1, r_l, r_f);
      step(1, 8'd33, 0, 1, 1'b1, r_l, r_f);
      do_reset();
      step(1, 8'd1, 0, 1, 1'b1, r_l, r_f);
      step(1, 8'd2, 1, 1, 1'b1, r_l, r_f);
      chk("after_rst_max", max_l, 2);
      chk("after_rst_argmax", arg_l, 1);
      chk("after_rst_count", cnt_l, 2);

      // reset while a result is pending and stalled
      step(1, 8'd60, 1, 0, 1'b1, r_l, r_f);
      step(1, 8'd61, 1, 0, 1'b1, r_l, r_f);
      do_reset();
      step(0, 8'd0, 0, 1, 1'b1, r_l, r_f);

      // randomized traffic, small values favour ties
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            v    = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            l    = ($urandom_range(0, 4) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            step(v, d, l, ordy, 1'b1, r_l, r_f);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
